// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array output collector.
package sys_array_pkg;

   // Collector control states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } collector_state_t;

   // Width of one array result lane (products are double width)
   function automatic int lane_w(input int data_width);
      return 2 * data_width;
   endfunction

   // Cycles from in_valid until every lane of that row is aligned
   function automatic int deskew_depth(input int base_lat, input int array_w);
      return base_lat + array_w - 1;
   endfunction

endpackage

// File: rtl/sys_array_row_fifo.sv
// Aligned-row FIFO. The read port is a register that always holds the head
// entry, so a write into an empty FIFO is visible one cycle later. A write
// on a full FIFO is only accepted when a read frees a slot on the same edge.
module sys_array_row_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_next;
   logic [AW:0]      rd_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_wr;
   logic             do_rd;
   logic [WIDTH-1:0] head_next;

   // Extra pointer MSB distinguishes full from empty
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_next = rd_ptr + (AW+1)'(do_rd);
   assign wr_next = wr_ptr + (AW+1)'(do_wr);

   // Head entry after this edge; a write landing as the only entry bypasses memory
   always_comb begin
      head_next = mem[rd_next[AW-1:0]];
      if (do_wr && (rd_next == wr_ptr)) head_next = wr_data;
   end

   // Storage array, no reset needed since reads are qualified by the pointers
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Pointer update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
      end
   end

   // Registered read port; data only moves when a head entry exists so it
   // holds steady while the consumer stalls
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= (wr_next != rd_next);
         if (wr_next != rd_next) rd_data <= head_next;
      end
   end

endmodule

// File: rtl/sys_array_out_collector.sv
// Output collector for the systolic array: deskews the diagonal column
// results back into whole rows, queues them, and hands them downstream with
// valid/ready and a last-row flag.
// Optional feature: define SYS_COLLECTOR_OVF_EN to get the sticky `overflow`
// output, which flags a row dropped on a full FIFO.
module sys_array_out_collector
   import sys_array_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_W    = 4,
   parameter int ARRAY_L    = 4,
   parameter int BASE_LAT   = ARRAY_L,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              in_valid,
   input  logic                              in_last,
   input  logic [2*DATA_WIDTH*ARRAY_W-1:0]   out_module,
   output logic [2*DATA_WIDTH*ARRAY_W-1:0]   res_data,
   output logic                              res_valid,
   output logic                              res_last,
   input  logic                              res_ready,
   output logic                              busy
`ifdef SYS_COLLECTOR_OVF_EN
   ,
   output logic                              overflow
`endif
);
   localparam int LW = lane_w(DATA_WIDTH);
   localparam int D  = deskew_depth(BASE_LAT, ARRAY_W);
   localparam int RW = LW * ARRAY_W;

   collector_state_t           state;
   logic                       tag;
   logic [D:1]                 vld_pipe;
   logic [D:1]                 last_pipe;
   logic                       row_vld;
   logic                       row_last;
   logic [ARRAY_W-1:0][LW-1:0] aligned;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       fifo_rd;
   logic                       wr_ok;
   logic [RW:0]                fifo_q;

   // Rows are tagged in IDLE/RUN; in_valid during DRAIN belongs to no batch
   assign tag = in_valid && (state != DRAIN);

   // Column j arrives j cycles after column 0, so it needs ARRAY_W-1-j delays
   for (genvar j = 0; j < ARRAY_W; j++) begin : g_lane
      localparam int NS = ARRAY_W - 1 - j;
      if (NS == 0) begin : g_pass
         assign aligned[j] = out_module[LW*j +: LW];
      end else begin : g_dly
         logic [NS-1:0][LW-1:0] sr;
         // Delay this column's results toward the alignment point
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               sr <= '0;
            end else begin
               sr[0] <= out_module[LW*j +: LW];
               for (int k = 1; k < NS; k++) sr[k] <= sr[k-1];
            end
         end
         assign aligned[j] = sr[NS-1];
      end
   end

   // Row tags travel D cycles so they meet the aligned row
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         vld_pipe[1]  <= tag;
         last_pipe[1] <= tag && in_last;
         for (int k = 2; k <= D; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            last_pipe[k] <= last_pipe[k-1];
         end
      end
   end

   assign row_vld  = vld_pipe[D];
   assign row_last = last_pipe[D];

   // A read on the same edge frees the slot, so a full FIFO still accepts
   assign fifo_rd = res_ready && !fifo_empty;
   assign wr_ok   = row_vld && (!fifo_full || fifo_rd);

   sys_array_row_fifo #(
      .WIDTH (RW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_ok),
      .wr_data  ({row_last, aligned}),
      .rd_en    (res_ready),
      .rd_data  (fifo_q),
      .rd_valid (res_valid),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign res_data = fifo_q[RW-1:0];
   assign res_last = fifo_q[RW];

   // Batch control; the batch ends when its last row leaves the deskew
   // pipe, whether the FIFO took it or not
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= in_last ? DRAIN : RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (in_valid && in_last) state <= DRAIN;
            end
            DRAIN: begin
               if (row_vld && row_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SYS_COLLECTOR_OVF_EN
   // Sticky record of any aligned row lost to a full FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                overflow <= 1'b0;
      else if (row_vld && !wr_ok)  overflow <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_sys_array_out_collector.sv
// Bench for sys_array_out_collector. A behavioural array model replays
// synthetic column results with the diagonal skew, and a row-queue model
// predicts what the consumer side must see every cycle.
module tb_sys_array_out_collector;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int BL = 4;
   localparam int FD = 4;
   localparam int LW = 2 * DW;
   localparam int RW = LW * AW;
   localparam int D  = BL + AW - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          res_ready = 1'b0;
   logic [RW-1:0] out_module = '0;
   logic [RW-1:0] res_data;
   logic          res_valid;
   logic          res_last;
   logic          busy;
`ifdef SYS_COLLECTOR_OVF_EN
   logic          overflow;
`endif

   always #5 clk = ~clk;

   sys_array_out_collector #(
      .DATA_WIDTH (DW),
      .ARRAY_W    (AW),
      .ARRAY_L    (4),
      .BASE_LAT   (BL),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .out_module (out_module),
      .res_data   (res_data),
      .res_valid  (res_valid),
      .res_last   (res_last),
      .res_ready  (res_ready),
      .busy       (busy)
`ifdef SYS_COLLECTOR_OVF_EN
      ,
      .overflow   (overflow)
`endif
   );

   int checks = 0;
   int passes = 0;
   int hs_cnt = 0;
   int e = 0;

   // Array model: per-edge schedule of column results
   logic [LW-1:0] lane_d [64][AW];
   bit            lane_v [64][AW];
   // Rows reaching alignment, per edge
   bit            arr_v [64];
   logic [RW-1:0] arr_d [64];
   bit            arr_l [64];
   // Consumer-side queue model
   logic [RW-1:0] q_data [$];
   bit            q_last [$];
   bit            m_busy, m_drain, m_ovf;
   logic [7:0]    row_id = 8'h00;
   // Expected outputs after the latest edge
   bit            exp_v, exp_l, exp_busy, exp_ovf;
   logic [RW-1:0] exp_d;

   function automatic logic [RW-1:0] row_word(input logic [7:0] r);
      logic [RW-1:0] w;
      w = '0;
      for (int j = 0; j < AW; j++) w[j*LW +: LW] = {r, 8'(j)};
      return w;
   endfunction

   task automatic model_clear();
      q_data.delete();
      q_last.delete();
      for (int s = 0; s < 64; s++) begin
         arr_v[s] = 1'b0;
         for (int j = 0; j < AW; j++) lane_v[s][j] = 1'b0;
      end
      m_busy = 1'b0; m_drain = 1'b0; m_ovf = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, land on the next negedge
   task automatic tick(input bit v, input bit l, input bit rdy);
      int s;
      logic [RW-1:0] rw;
      in_valid = v; in_last = l; res_ready = rdy;
      s = e % 64;
      for (int j = 0; j < AW; j++) begin
         out_module[j*LW +: LW] = lane_v[s][j] ? lane_d[s][j] : LW'($urandom);
         lane_v[s][j] = 1'b0;
      end
      if (res_valid && rdy) hs_cnt++;
      if (q_data.size() > 0 && rdy) begin
         void'(q_data.pop_front());
         void'(q_last.pop_front());
      end
      if (v && !m_drain) begin
         rw = row_word(row_id);
         row_id++;
         for (int j = 0; j < AW; j++) begin
            lane_d[(e+BL+j)%64][j] = rw[j*LW +: LW];
            lane_v[(e+BL+j)%64][j] = 1'b1;
         end
         arr_v[(e+D)%64] = 1'b1;
         arr_d[(e+D)%64] = rw;
         arr_l[(e+D)%64] = l;
         m_busy = 1'b1;
         if (l) m_drain = 1'b1;
      end
      if (arr_v[s]) begin
         arr_v[s] = 1'b0;
         if (q_data.size() < FD) begin
            q_data.push_back(arr_d[s]);
            q_last.push_back(arr_l[s]);
         end else begin
            m_ovf = 1'b1;
         end
         if (arr_l[s]) begin
            m_busy = 1'b0;
            m_drain = 1'b0;
         end
      end
      @(posedge clk);
      e++;
      @(negedge clk);
      exp_v = (q_data.size() > 0);
      exp_d = exp_v ? q_data[0] : '0;
      exp_l = exp_v ? q_last[0] : 1'b0;
      exp_busy = m_busy;
      exp_ovf = m_ovf;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_clear();
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", res_valid); else passes++;
      checks++; if (res_data !== '0) $display("FAIL reset_data: got %h exp 0", res_data); else passes++;
      checks++; if (res_last !== 1'b0) $display("FAIL reset_last: got %b exp 0", res_last); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passes++;
`ifdef SYS_COLLECTOR_OVF_EN
      checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", overflow); else passes++;
`endif
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      int first_v;
      first_v = -1;
      hs_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick(i < 4, i == 3, 1'b1);
         checks++; if (res_valid !== exp_v) $display("FAIL basic_valid: got %b exp %b", res_valid, exp_v); else passes++;
         if (exp_v) begin checks++; if ({res_last, res_data} !== {exp_l, exp_d}) $display("FAIL basic_row: got %b/%h exp %b/%h", res_last, res_data, exp_l, exp_d); else passes++; end
         checks++; if (busy !== exp_busy) $display("FAIL basic_busy: got %b exp %b", busy, exp_busy); else passes++;
         if (res_valid && first_v < 0) first_v = i + 1;
      end
      checks++; if (first_v != D + 1) $display("FAIL basic_latency: got %0d exp %0d", first_v, D + 1); else passes++;
      checks++; if (hs_cnt != 4) $display("FAIL basic_rows: got %0d exp 4", hs_cnt); else passes++;
   endtask

   task automatic test_stall();
      hs_cnt = 0;
      for (int i = 0; i < 22; i++) begin
         tick(i < 4, i == 3, i >= 12);
         checks++; if (res_valid !== exp_v) $display("FAIL stall_valid: got %b exp %b", res_valid, exp_v); else passes++;
         if (exp_v) begin checks++; if ({res_last, res_data} !== {exp_l, exp_d}) $display("FAIL stall_row: got %b/%h exp %b/%h", res_last, res_data, exp_l, exp_d); else passes++; end
         checks++; if (busy !== exp_busy) $display("FAIL stall_busy: got %b exp %b", busy, exp_busy); else passes++;
      end
      checks++; if (hs_cnt != 4) $display("FAIL stall_rows: got %0d exp 4", hs_cnt); else passes++;
`ifdef SYS_COLLECTOR_OVF_EN
      checks++; if (overflow !== 1'b0) $display("FAIL stall_ovf: got %b exp 0", overflow); else passes++;
`endif
   endtask

   task automatic test_full_rw();
      hs_cnt = 0;
      // Row 4 aligns on edge 11, exactly when the FIFO holds rows 0-3
      for (int i = 0; i < 28; i++) begin
         tick(i < 5, i == 4, (i == 11) || (i >= 17));
         checks++; if (res_valid !== exp_v) $display("FAIL fullrw_valid: got %b exp %b", res_valid, exp_v); else passes++;
         if (exp_v) begin checks++; if ({res_last, res_data} !== {exp_l, exp_d}) $display("FAIL fullrw_row: got %b/%h exp %b/%h", res_last, res_data, exp_l, exp_d); else passes++; end
         checks++; if (busy !== exp_busy) $display("FAIL fullrw_busy: got %b exp %b", busy, exp_busy); else passes++;
      end
      checks++; if (hs_cnt != 5) $display("FAIL fullrw_rows: got %0d exp 5", hs_cnt); else passes++;
`ifdef SYS_COLLECTOR_OVF_EN
      checks++; if (overflow !== 1'b0) $display("FAIL fullrw_ovf: got %b exp 0", overflow); else passes++;
`endif
   endtask

   task automatic test_overflow();
      logic [7:0] base;
      logic [RW-1:0] first_row;
      base = row_id;
      first_row = '0;
      hs_cnt = 0;
      for (int i = 0; i < 28; i++) begin
         tick(i < 6, i == 5, i >= 16);
         checks++; if (res_valid !== exp_v) $display("FAIL ovf_valid: got %b exp %b", res_valid, exp_v); else passes++;
         if (exp_v) begin checks++; if ({res_last, res_data} !== {exp_l, exp_d}) $display("FAIL ovf_row: got %b/%h exp %b/%h", res_last, res_data, exp_l, exp_d); else passes++; end
         checks++; if (busy !== exp_busy) $display("FAIL ovf_busy: got %b exp %b", busy, exp_busy); else passes++;
         if (i == 15) begin
            first_row = res_data;
            checks++; if (busy !== 1'b0) $display("FAIL ovf_idle: got %b exp 0", busy); else passes++;
`ifdef SYS_COLLECTOR_OVF_EN
            checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", overflow); else passes++;
`endif
         end
      end
      checks++; if (first_row !== row_word(base)) $display("FAIL ovf_head: got %h exp %h", first_row, row_word(base)); else passes++;
      checks++; if (hs_cnt != 4) $display("FAIL ovf_rows: got %0d exp 4", hs_cnt); else passes++;
   endtask

   task automatic test_drain_ignore();
      hs_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick((i < 3) || i == 3 || i == 5 || i == 6 || i == 8, i == 2 || i == 6, 1'b1);
         checks++; if (res_valid !== exp_v) $display("FAIL drain_valid: got %b exp %b", res_valid, exp_v); else passes++;
         if (exp_v) begin checks++; if ({res_last, res_data} !== {exp_l, exp_d}) $display("FAIL drain_row: got %b/%h exp %b/%h", res_last, res_data, exp_l, exp_d); else passes++; end
         checks++; if (busy !== exp_busy) $display("FAIL drain_busy: got %b exp %b", busy, exp_busy); else passes++;
      end
      checks++; if (hs_cnt != 3) $display("FAIL drain_rows: got %0d exp 3", hs_cnt); else passes++;
   endtask

   task automatic test_reset_mid();
      // Batch of four with consumer stalled; after edge 8 two rows are queued
      for (int i = 0; i < 9; i++) tick(i < 4, i == 3, 1'b0);
      checks++; if (res_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b exp 1", res_valid); else passes++;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (res_valid !== 1'b0) $display("FAIL rmid_valid: got %b exp 0", res_valid); else passes++;
      checks++; if (res_data !== '0) $display("FAIL rmid_data: got %h exp 0", res_data); else passes++;
      checks++; if (res_last !== 1'b0) $display("FAIL rmid_last: got %b exp 0", res_last); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b exp 0", busy); else passes++;
`ifdef SYS_COLLECTOR_OVF_EN
      checks++; if (overflow !== 1'b0) $display("FAIL rmid_ovf: got %b exp 0", overflow); else passes++;
`endif
      model_clear();
      @(posedge clk);
      e++;
      @(negedge clk);
      reset_n = 1'b1;
      hs_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick(i < 4, i == 3, 1'b1);
         checks++; if (res_valid !== exp_v) $display("FAIL rmid_post_valid: got %b exp %b", res_valid, exp_v); else passes++;
         if (exp_v) begin checks++; if ({res_last, res_data} !== {exp_l, exp_d}) $display("FAIL rmid_post_row: got %b/%h exp %b/%h", res_last, res_data, exp_l, exp_d); else passes++; end
         checks++; if (busy !== exp_busy) $display("FAIL rmid_post_busy: got %b exp %b", busy, exp_busy); else passes++;
      end
      checks++; if (hs_cnt != 4) $display("FAIL rmid_post_rows: got %0d exp 4", hs_cnt); else passes++;
   endtask

   task automatic test_random();
      bit v, l, r;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 2) == 0);
         l = v && ($urandom_range(0, 3) == 0);
         r = (i >= 380) || ($urandom_range(0, 2) != 0);
         if (i >= 380) v = 1'b0;
         tick(v, l, r);
         checks++; if (res_valid !== exp_v) $display("FAIL rand_valid: got %b exp %b", res_valid, exp_v); else passes++;
         if (exp_v) begin checks++; if ({res_last, res_data} !== {exp_l, exp_d}) $display("FAIL rand_row: got %b/%h exp %b/%h", res_last, res_data, exp_l, exp_d); else passes++; end
         checks++; if (busy !== exp_busy) $display("FAIL rand_busy: got %b exp %b", busy, exp_busy); else passes++;
`ifdef SYS_COLLECTOR_OVF_EN
         checks++; if (overflow !== exp_ovf) $display("FAIL rand_ovf: got %b exp %b", overflow, exp_ovf); else passes++;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_full_rw();
      test_overflow();
      test_drain_ignore();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
